// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
package mips_mem_pkg;

    localparam int WAIT_CNT_W = 4;
    localparam int WORD_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write and read share one enable; read returns pre-write data.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

    // Contents are deliberately left out of reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data port responder: captures a read/write request, waits WAIT_STATES cycles,
// performs the access on the internal array and pulses mem_ready for one cycle.
//
// state | meaning
// IDLE  | no access outstanding; a request is captured here
// WAIT  | counting down wait states; access performed when cnt reaches 1
// RESP  | mem_ready asserted for one cycle, read data valid
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int DEPTH_LOG2  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] mem_Address,
    input  logic [31:0] mem_Write_data,
    output logic [31:0] mem_Read_data,
    output logic        mem_ready,
    output logic        mem_stall,
    output logic        mem_misalign
);

    state_t                  state, state_next;
    logic [WAIT_CNT_W-1:0]   cnt, cnt_next;
    logic                    op_we;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [WORD_W-1:0]       wdata_q;
    logic                    mis_q;

    logic                    req;
    logic                    capture;
    logic                    acc_en;
    logic                    acc_we;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic [WORD_W-1:0]       acc_wdata;
    logic [DEPTH_LOG2-1:0]   in_idx;
    logic                    unused_addr_bits;

    assign req              = MemRead | MemWrite;
    assign in_idx           = mem_Address[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^mem_Address[31:DEPTH_LOG2+2];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        acc_en     = 1'b0;
        acc_we     = op_we;
        acc_idx    = idx_q;
        acc_wdata  = wdata_q;
        case (state)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        // Zero wait states: the live inputs are the captured values on this edge.
                        acc_en     = 1'b1;
                        acc_we     = MemWrite;
                        acc_idx    = in_idx;
                        acc_wdata  = mem_Write_data;
                        state_next = RESP;
                    end else begin
                        cnt_next   = WAIT_CNT_W'(WAIT_STATES);
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - WAIT_CNT_W'(1);
                if (cnt == WAIT_CNT_W'(1)) begin
                    acc_en     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op_we   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                op_we   <= MemWrite;
                idx_q   <= in_idx;
                wdata_q <= mem_Write_data;
                mis_q   <= |mem_Address[1:0];
            end
        end
    end

    // Reset must also block the array so an in-flight write is dropped.
    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (acc_en & ~reset),
        .we    (acc_we),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (mem_Read_data)
    );

    assign mem_ready    = (state == RESP);
    assign mem_misalign = mem_ready & mis_q;
    assign mem_stall    = req & ~mem_ready;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the pipeline's MEM-stage data port. It accepts MemRead/MemWrite requests carrying an address and write data, and services them against an internal word array after a configurable number of wait states. It returns read data with a one-cycle `mem_ready` pulse and drives `mem_stall` so the pipeline can freeze while an access is outstanding.

## Interface
- `WAIT_STATES`, default 2: extra cycles before the access completes; legal range 0–15.
- `DEPTH_LOG2`, default 8: log2 of the array depth in 32-bit words (256 words).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `MemRead`  in  1  read request, level, held until `mem_ready`.
- `MemWrite`  in  1  write request, level, held until `mem_ready`.
- `mem_Address`  in  32  byte address; word index = `mem_Address[DEPTH_LOG2+1:2]`.
- `mem_Write_data`  in  32  store data.
- `mem_Read_data`  out  32  load data, valid while `mem_ready`=1.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_stall`  out  1  `(MemRead|MemWrite) & ~mem_ready`, combinational.
- `mem_misalign`  out  1  high with `mem_ready` when the captured `addr[1:0]`≠0.

## Operation
- Request = `MemRead|MemWrite`.
- If both are set, the access is a write. `mem_Read_data` then returns the word's value from before the write.
- In IDLE, on a request, capture the op, word index, write data and the misalign bit.
  - `WAIT_STATES`=0: perform the access on this edge and go to RESP.
  - Otherwise: load `cnt`=`WAIT_STATES` and go to WAIT.
- WAIT: decrement `cnt` each edge. On the edge where `cnt`==1, perform the access and go to RESP.
- RESP: assert `mem_ready`. Drive `mem_misalign` = captured bit. Go to IDLE on the next edge regardless of the inputs.
- The access uses only the captured values. Input changes after capture are ignored.
- Misaligned addresses:
  - The low two bits are dropped and the access proceeds normally.
  - The write still commits.
  - `mem_misalign` is informational only.
- Addresses above the array depth wrap: upper bits are ignored.
- If the request drops mid-operation, the access still completes, including write commit, and `mem_ready` still pulses.

## Timing
- Request first present in cycle 0 → `mem_ready`=1 in cycle `WAIT_STATES`+1, for exactly one cycle.
- `mem_stall`=1 in cycles 0 … `WAIT_STATES`; 0 in the ready cycle.
- The write is visible to any read captured after the RESP cycle.
- Back-to-back requests: the cycle after RESP is IDLE, and a request held there is captured that cycle.
  - Throughput is one access per `WAIT_STATES`+2 cycles.
- Reset values: state IDLE, `cnt`=0, `mem_ready`=0, `mem_misalign`=0, `mem_Read_data`=0. `mem_stall` follows its equation.
- Reset mid-operation: return to IDLE. A pending, not-yet-committed write is discarded, and no `mem_ready` is produced.
- The array contents are not reset. Contents after power-up are undefined.
- Reset takes priority over every other transition.

## Structure
- Shared package `mips_mem_pkg`:
  - state enum IDLE/WAIT/RESP (2-bit encoding);
  - `WAIT_CNT_W`=4;
  - word-width constant 32.
- One sub-module, `dmem_array`:
  - single-port, `2**DEPTH_LOG2`×32;
  - synchronous write and synchronous read on the same enable;
  - read returns old data on a simultaneous write.
- FSM, counter and capture registers live in `data_mem_responder`.

## Test plan
- `WAIT_STATES`=2: write 0xDEADBEEF to 0x10, then read 0x10 → `mem_ready` in cycle 3 of each access, `mem_stall` high in cycles 0–2, read returns 0xDEADBEEF.
- `WAIT_STATES`=0: hold back-to-back reads of 0x10 and 0x14 → `mem_ready` every second cycle, `mem_stall` 0 in each ready cycle.
- Write 0x11111111 to 0x20, then issue MemRead and MemWrite together with data 0x22222222 at 0x20 → returns 0x11111111; a following read returns 0x22222222.
- Write to 0x23 → `mem_misalign`=1 with `mem_ready`; a read of 0x20 returns the written word.
- `WAIT_STATES`=3: start a write of 0xA5A5A5A5 to 0x30 (prior content 0x0), assert `reset` in cycle 2 → no `mem_ready`, state IDLE; a read of 0x30 returns 0x0.
- Change `mem_Address` and data in cycle 1 of a `WAIT_STATES`=2 write to 0x40 → the write lands at 0x40 with the originally captured data.
